// File: rtl/fifo_uart_tx_pkg.sv
// rtl/fifo_uart_tx_pkg.sv - shared state encodings and UART constants for fifo_uart_tx
package fifo_uart_tx_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_POP    = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_START  = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
  localparam logic [2:0] ST_PARITY = 3'd5;
  localparam logic [2:0] ST_STOP   = 3'd6;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    POP    = ST_POP,
    LOAD   = ST_LOAD,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter; tick marks the last rclk cycle of each bit
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic rclk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] baud_cnt_q;
  logic [CW-1:0] baud_cnt_d;

  always_comb begin
    baud_cnt_d = baud_cnt_q;
    if (clear || (baud_cnt_q == LAST)) begin
      baud_cnt_d = '0;
    end else begin
      baud_cnt_d = baud_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      baud_cnt_q <= '0;
    end else begin
      baud_cnt_q <= baud_cnt_d;
    end
  end

  assign tick = !clear && (baud_cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - FIFO-draining 8N1/8N2 UART transmitter on rclk
// Optional even parity bit (8E1/8E2) when FIFO_UART_TX_PARITY_EN is defined.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic       rclk,
  input  logic       reset,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_rdata,
  output logic       fifo_read_en,
  output logic       tx,
  output logic       busy,
  output logic       byte_done
);

  localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_BITS - 1);
  localparam logic       STOP_LAST = (STOP_BITS == 2);

  state_e     state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       stop_idx_q, stop_idx_d;
  logic       tick;
  logic       baud_clear;
`ifdef FIFO_UART_TX_PARITY_EN
  logic       par_q, par_d;
`endif

  // Holding the counter clear until START guarantees a full-length start bit.
  assign baud_clear = (state_q == IDLE) || (state_q == POP) || (state_q == LOAD);

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .rclk  (rclk),
    .reset (reset),
    .clear (baud_clear),
    .tick  (tick)
  );

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    byte_done  = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      IDLE: if (enable && !fifo_empty) state_d = POP;
      POP:  state_d = LOAD;
      LOAD: begin
        shreg_d    = fifo_rdata;
        bit_idx_d  = '0;
        stop_idx_d = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
        par_d      = ^fifo_rdata;
`endif
        state_d    = START;
      end
      START: if (tick) state_d = DATA;
      DATA: begin
        if (tick) begin
          shreg_d   = shreg_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == LAST_BIT) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: if (tick) state_d = STOP;
`endif
      STOP: begin
        if (tick) begin
          if (stop_idx_q == STOP_LAST) begin
            byte_done  = 1'b1;
            stop_idx_d = 1'b0;
            state_d    = (enable && !fifo_empty) ? POP : IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  always_comb begin
    tx = UART_IDLE_LEVEL;
    case (state_q)
      START:  tx = 1'b0;
      DATA:   tx = shreg_q[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: tx = par_q;
`endif
      default: tx = UART_IDLE_LEVEL;
    endcase
  end

  assign fifo_read_en = (state_q == POP);
  assign busy         = (state_q != IDLE);

endmodule
